regbank_write_arbiter: RTL and testbench

- Shares the register bank's single write port between two writeback sources: ex (ALU/execute result) and ld (load-data return).
- Round-robin arbitration with valid/ready handshakes.
- Registers the winning write and drives the bank's regWrite/writeReg/writeData.
- Drops writes to X31 (XZR) and exposes the in-flight write for hazard logic.

---
 rtl/regbank_write_arbiter.sv | 103 ++++++++++
 tb/tb_regbank_write_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank write port between execute and load writeback.
// Optional read-port forwarding from the output stage is enabled by defining REGBANK_WR_FWD_EN.
module regbank_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef REGBANK_WR_FWD_EN
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
`endif
    output logic              regWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              pend_valid,
    output logic [ADDR_W-1:0] pend_addr
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic              rrPtr;
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1;

    logic              exGrant;
    logic              ldGrant;
    logic              xfer_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic              keep_p0;

    // Grant stage: rrPtr only breaks ties; a lone requester always wins.
    always_comb begin
        exGrant = 1'b0;
        ldGrant = 1'b0;
        if (!rst && !freeze) begin
            exGrant = ex_valid && (!ld_valid || !rrPtr);
            ldGrant = ld_valid && (!ex_valid || rrPtr);
        end
    end

    assign ex_ready = exGrant;
    assign ld_ready = ldGrant;

    always_comb begin
        xfer_p0 = exGrant || ldGrant;
        addr_p0 = ldGrant ? ld_addr : ex_addr;
        data_p0 = ldGrant ? ld_data : ex_data;
        // XZR transfers complete the handshake but never reach the bank.
        keep_p0 = xfer_p0 && (addr_p0 != ZERO_IDX);
    end

    // Output stage: one registered write, held while frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            rrPtr   <= 1'b0;
            vld_p1  <= 1'b0;
            addr_p1 <= '0;
            data_p1 <= '0;
        end else if (!freeze) begin
            if (exGrant) begin
                rrPtr <= 1'b1;
            end else if (ldGrant) begin
                rrPtr <= 1'b0;
            end
            vld_p1 <= keep_p0;
            if (keep_p0) begin
                addr_p1 <= addr_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign regWrite   = vld_p1 && !freeze;
    assign writeReg   = addr_p1;
    assign writeData  = data_p1;
    assign pend_valid = vld_p1;
    assign pend_addr  = addr_p1;

`ifdef REGBANK_WR_FWD_EN
    assign fwd_hit1  = vld_p1 && (rd_addr1 == addr_p1) && (rd_addr1 != ZERO_IDX);
    assign fwd_hit2  = vld_p1 && (rd_addr2 == addr_p1) && (rd_addr2 != ZERO_IDX);
    assign fwd_data1 = data_p1;
    assign fwd_data2 = data_p1;
`endif

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter with hand-computed expectations.
// Also covers the forwarding ports when REGBANK_WR_FWD_EN is defined.
module tb_regbank_write_arbiter;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              freeze;
    logic              ex_valid;
    logic              ex_ready;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_addr;
`ifdef REGBANK_WR_FWD_EN
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              fwd_hit1;
    logic              fwd_hit2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
`endif

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    regbank_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(31)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .ex_valid(ex_valid),
        .ex_ready(ex_ready),
        .ex_addr(ex_addr),
        .ex_data(ex_data),
        .ld_valid(ld_valid),
        .ld_ready(ld_ready),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
`ifdef REGBANK_WR_FWD_EN
        .rd_addr1(rd_addr1),
        .rd_addr2(rd_addr2),
        .fwd_hit1(fwd_hit1),
        .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1),
        .fwd_data2(fwd_data2),
`endif
        .regWrite(regWrite),
        .writeReg(writeReg),
        .writeData(writeData),
        .pend_valid(pend_valid),
        .pend_addr(pend_addr)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0;
        ex_valid = 1'b1; ex_addr = 5'd9; ex_data = 64'hDEAD;
        ld_valid = 1'b1; ld_addr = 5'd10; ld_data = 64'hBEEF;
`ifdef REGBANK_WR_FWD_EN
        rd_addr1 = '0; rd_addr2 = '0;
`endif
        // Reset held two cycles with both sources requesting
        tick();
        tick();
        chk("rst_regWrite", regWrite, 0);
        chk("rst_pend_valid", pend_valid, 0);
        chk("rst_writeReg", writeReg, 0);
        chk("rst_writeData", writeData, 0);
        chk("rst_ex_ready", ex_ready, 0);
        chk("rst_ld_ready", ld_ready, 0);

        // Idle after release
        rst = 1'b0; ex_valid = 1'b0; ld_valid = 1'b0;
        #1;
        chk("idle_ex_ready", ex_ready, 0);
        chk("idle_ld_ready", ld_ready, 0);
        tick();
        chk("idle_regWrite", regWrite, 0);

        // Contention from reset: ex, ld, ex, ld
        ex_valid = 1'b1; ex_addr = 5'd1; ex_data = 64'h11;
        ld_valid = 1'b1; ld_addr = 5'd2; ld_data = 64'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("cont_ex_ready", ex_ready, (k % 2 == 0) ? 1 : 0);
            chk("cont_ld_ready", ld_ready, (k % 2 == 0) ? 0 : 1);
            tick();
            chk("cont_regWrite", regWrite, 1);
            chk("cont_writeReg", writeReg, (k % 2 == 0) ? 1 : 2);
            chk("cont_writeData", writeData, (k % 2 == 0) ? 64'h11 : 64'h22);
        end
        ex_valid = 1'b0; ld_valid = 1'b0;
        tick();
        chk("cont_drain_regWrite", regWrite, 0);

        // Single execute write, one-cycle latency
        ex_valid = 1'b1; ex_addr = 5'd3; ex_data = 64'h1234;
        #1;
        chk("single_ex_ready", ex_ready, 1);
        chk("single_ld_ready", ld_ready, 0);
        tick();
        ex_valid = 1'b0;
        chk("single_regWrite", regWrite, 1);
        chk("single_writeReg", writeReg, 3);
        chk("single_writeData", writeData, 64'h1234);
        chk("single_pend_valid", pend_valid, 1);
        chk("single_pend_addr", pend_addr, 3);
        tick();
        chk("single_after_regWrite", regWrite, 0);

        // XZR drop (rrPtr is 1 after the ex grant)
        ld_valid = 1'b1; ld_addr = 5'd31; ld_data = 64'hFF;
        #1;
        chk("xzr_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        chk("xzr_regWrite", regWrite, 0);
        chk("xzr_pend_valid", pend_valid, 0);
        ex_valid = 1'b1; ex_addr = 5'd4; ld_valid = 1'b1; ld_addr = 5'd6;
        #1;
        chk("xzr_rr_ex_ready", ex_ready, 1);
        chk("xzr_rr_ld_ready", ld_ready, 0);
        ex_valid = 1'b0; ld_valid = 1'b0;

        // Freeze holds the accepted write for three cycles
        ex_valid = 1'b1; ex_addr = 5'd5; ex_data = 64'h55;
        tick();
        ex_valid = 1'b0; freeze = 1'b1;
        ld_valid = 1'b1; ld_addr = 5'd8; ld_data = 64'h88;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("frz_regWrite", regWrite, 0);
            chk("frz_pend_valid", pend_valid, 1);
            chk("frz_pend_addr", pend_addr, 5);
            chk("frz_ld_ready", ld_ready, 0);
            tick();
        end
        freeze = 1'b0; ld_valid = 1'b0;
        #1;
        chk("unfrz_regWrite", regWrite, 1);
        chk("unfrz_writeReg", writeReg, 5);
        chk("unfrz_writeData", writeData, 64'h55);
        tick();
        chk("unfrz_after_regWrite", regWrite, 0);

        // Same address from both sources: rrPtr=1 so ld first, ex next
        ex_valid = 1'b1; ex_addr = 5'd9; ex_data = 64'hA;
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 64'hB;
        tick();
        ld_valid = 1'b0;
        chk("same_first_data", writeData, 64'hB);
        tick();
        chk("same_second_regWrite", regWrite, 1);
        chk("same_second_data", writeData, 64'hA);

        // Back-to-back from a lone source
        for (int k = 0; k < 3; k++) begin
            ex_addr = 5'(10 + k); ex_data = 64'(100 + k);
            #1;
            chk("b2b_ex_ready", ex_ready, 1);
            tick();
            chk("b2b_regWrite", regWrite, 1);
            chk("b2b_writeReg", writeReg, 10 + k);
            chk("b2b_writeData", writeData, 100 + k);
        end
        ex_valid = 1'b0;

        // Reset mid-operation discards the pending write
        ex_valid = 1'b1; ex_addr = 5'd12; ex_data = 64'hC;
        tick();
        chk("midrst_pend_before", pend_valid, 1);
        rst = 1'b1; ex_valid = 1'b1;
        #1;
        chk("midrst_ex_ready", ex_ready, 0);
        tick();
        chk("midrst_regWrite", regWrite, 0);
        chk("midrst_pend_valid", pend_valid, 0);
        rst = 1'b0; ex_valid = 1'b0;
        tick();

`ifdef REGBANK_WR_FWD_EN
        ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 64'hAB;
        tick();
        ex_valid = 1'b0;
        rd_addr1 = 5'd7; rd_addr2 = 5'd31;
        #1;
        chk("fwd_hit1", fwd_hit1, 1);
        chk("fwd_data1", fwd_data1, 64'hAB);
        chk("fwd_hit2", fwd_hit2, 0);
        rd_addr2 = 5'd7;
        #1;
        chk("fwd_hit2_match", fwd_hit2, 1);
        chk("fwd_data2", fwd_data2, 64'hAB);
        tick();
        chk("fwd_hit1_idle", fwd_hit1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
